// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain master: serializes host words LSB-first onto ccff_head and
// optionally re-shifts the same bitstream while checking the looped-back ccff_tail.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              verify_en,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ERR_W-1:0]  mismatch_count
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CntW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [LEN_W-1:0]  bits_left_q, bits_left_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              verify_q, verify_d;
  logic              head_q, head_d;
  logic              shift_q, shift_d;
  logic              vbit_q, vbit_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic [ERR_W-1:0]  cnt_q, cnt_d;

  logic              active;
  logic              accept;
  logic              have_bit;
  logic              cur_bit;
  logic [LEN_W-1:0]  need;
  logic [CntW-1:0]   take;

  assign active     = (state_q == StLoad) || (state_q == StVerify);
  // Bits still to be fetched from the host beyond what the buffer already holds.
  assign need       = bits_left_q - LEN_W'(buf_cnt_q);
  assign word_ready = active && (buf_cnt_q <= CntW'(1)) && (bits_left_q > LEN_W'(buf_cnt_q));
  assign accept     = word_ready && word_valid;
  assign take       = (need >= LEN_W'(WORD_W)) ? CntW'(WORD_W) : CntW'(need);
  assign have_bit   = (buf_cnt_q != '0) || accept;
  assign cur_bit    = (buf_cnt_q != '0) ? buf_q[0] : word_in[0];

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    bits_left_d = bits_left_q;
    len_d       = len_q;
    verify_d    = verify_q;
    head_d      = head_q;
    shift_d     = 1'b0;
    vbit_d      = 1'b0;
    done_d      = 1'b0;
    mis_d       = mis_q;
    cnt_d       = cnt_q;

    if (abort) begin
      state_d   = StIdle;
      buf_d     = '0;
      buf_cnt_d = '0;
    end else begin
      // The fabric captures head_q on this edge; the tail shows the pass-1 bit now.
      if (shift_q && vbit_q && (ccff_tail != head_q)) begin
        mis_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_d       = chain_len;
            verify_d    = verify_en;
            bits_left_d = chain_len;
            mis_d       = 1'b0;
            cnt_d       = '0;
            buf_cnt_d   = '0;
            state_d     = (chain_len == '0) ? StDone : StLoad;
          end
        end
        StLoad, StVerify: begin
          if (have_bit) begin
            head_d      = cur_bit;
            shift_d     = 1'b1;
            vbit_d      = (state_q == StVerify);
            bits_left_d = bits_left_q - LEN_W'(1);
            if (buf_cnt_q != '0) begin
              buf_d     = buf_q >> 1;
              buf_cnt_d = buf_cnt_q - CntW'(1);
            end
            if (accept) begin
              if (buf_cnt_q != '0) begin
                buf_d     = word_in;
                buf_cnt_d = take;
              end else begin
                buf_d     = word_in >> 1;
                buf_cnt_d = take - CntW'(1);
              end
            end
            if (bits_left_q == LEN_W'(1)) begin
              if ((state_q == StLoad) && verify_q) begin
                state_d     = StVerify;
                bits_left_d = len_q;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      bits_left_q <= '0;
      len_q       <= '0;
      verify_q    <= 1'b0;
      head_q      <= 1'b0;
      shift_q     <= 1'b0;
      vbit_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      bits_left_q <= bits_left_d;
      len_q       <= len_d;
      verify_q    <= verify_d;
      head_q      <= head_d;
      shift_q     <= shift_d;
      vbit_q      <= vbit_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ccff_head      = head_q;
  assign shift_en       = shift_q;
  assign busy           = active;
  assign done           = done_q;
  assign mismatch       = mis_q;
  assign mismatch_count = cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: directed and randomized loads against a bit-list
// reference, with a behavioural chain (optionally stuck) between head and tail.
module tb_ccff_bitstream_loader;

  localparam int unsigned WW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned EW = 16;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          verify_en = 1'b0;
  logic [LW-1:0] chain_len = '0;
  logic [WW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          ccff_tail;
  logic          word_ready, ccff_head, shift_en, busy, done, mismatch;
  logic [EW-1:0] mismatch_count;
  logic          d2_ready, d2_head, d2_shift, d2_busy, d2_done, d2_mis;
  logic [1:0]    d2_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] chain = '0;
  int          tb_len = 0;
  int          tb_fault = 0;  // 0 good chain, 1 tail stuck 0, 2 tail stuck 1
  logic [7:0]  tb_words [8];

  ccff_bitstream_loader #(.WORD_W(WW), .LEN_W(LW), .ERR_W(EW)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .abort(abort),
    .verify_en(verify_en), .chain_len(chain_len), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_count(mismatch_count)
  );

  ccff_bitstream_loader #(.WORD_W(WW), .LEN_W(LW), .ERR_W(2)) dut_sat (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .abort(abort),
    .verify_en(verify_en), .chain_len(chain_len), .word_in(word_in), .word_valid(word_valid),
    .word_ready(d2_ready), .ccff_head(d2_head), .shift_en(d2_shift), .ccff_tail(ccff_tail),
    .busy(d2_busy), .done(d2_done), .mismatch(d2_mis), .mismatch_count(d2_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) if (shift_en) chain <= {chain[62:0], ccff_head};

  assign ccff_tail = (tb_fault == 1) ? 1'b0 : (tb_fault == 2) ? 1'b1 :
                     (tb_len > 0) ? chain[tb_len-1] : 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full load (and optional verify) of len bits from tb_words, checked against the bit list.
  task automatic run_load(input string name, input int len, input bit ver, input int fault,
                          input int gmin, input int gmax, input bit poke);
    int   nwords, npass, total, idx, gap, nhs, ndone, expm;
    int   first_hs, first_shift, last_shift, done_cyc, stall_err, late_ready;
    bit   hs;
    logic prev_head;
    logic got_q[$];
    logic exp_q[$];
    nwords = (len + 7) / 8;
    npass  = ver ? 2 : 1;
    total  = nwords * npass;
    for (int i = 0; i < len; i++) exp_q.push_back(tb_words[i/8][i%8]);
    expm = 0;
    if (ver) foreach (exp_q[i]) if ((fault == 1 && exp_q[i]) || (fault == 2 && !exp_q[i])) expm++;
    tb_len = len;
    tb_fault = fault;
    idx = 0; gap = 0; nhs = 0; ndone = 0; stall_err = 0; late_ready = 0;
    first_hs = -1; first_shift = -1; last_shift = -1; done_cyc = -1; prev_head = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b1; chain_len = LW'(len); verify_en = ver; word_valid = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b0; word_valid = 1'b1; word_in = tb_words[0];
    for (int cyc = 1; cyc < 1000; cyc++) begin
      @(negedge prog_clk);
      hs = word_valid && word_ready;
      if (word_ready && idx >= total) late_ready++;
      if (hs) begin
        nhs++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (shift_en) begin
        got_q.push_back(ccff_head);
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
      end else if (cyc > 1 && ccff_head !== prev_head) begin
        stall_err++;
      end
      prev_head = ccff_head;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge prog_clk); #1;
      if (poke && cyc == 3) begin
        start = 1'b1;
        chain_len = LW'(1);
      end else begin
        start = 1'b0;
      end
      if (hs) begin
        idx++;
        gap = $urandom_range(gmax, gmin);
      end
      if (gap > 0) begin
        word_valid = 1'b0;
        gap--;
      end else if (idx < total) begin
        word_valid = 1'b1;
        word_in = tb_words[idx % nwords];
      end else begin
        word_valid = 1'b0;
        word_in = WW'($urandom);
      end
    end
    word_valid = 1'b0;
    start = 1'b0;
    check_eq({name, " done within budget"}, done_cyc >= 0, 1);
    check_eq({name, " shift count"}, got_q.size(), len * npass);
    for (int i = 0; i < got_q.size() && i < len * npass; i++)
      check_eq($sformatf("%s head bit %0d", name, i), got_q[i], exp_q[i % len]);
    check_eq({name, " words accepted"}, nhs, total);
    check_eq({name, " done pulses"}, ndone, 1);
    check_eq({name, " done after last shift"}, done_cyc, last_shift + 1);
    check_eq({name, " first shift latency"}, first_shift, first_hs + 1);
    check_eq({name, " head stable in stall"}, stall_err, 0);
    check_eq({name, " ready after final word"}, late_ready, 0);
    if (gmax == 0) check_eq({name, " gapless span"}, last_shift - first_shift + 1, len * npass);
    check_eq({name, " mismatch flag"}, mismatch, expm > 0);
    check_eq({name, " mismatch count"}, mismatch_count, expm);
    check_eq({name, " saturated count"}, d2_cnt, (expm > 3) ? 3 : expm);
    check_eq({name, " idle after done"}, busy, 0);
  endtask

  // Keep feeding words until the given number of shifts has been observed.
  task automatic feed_until(input int nwords, input int target);
    int idx = 0;
    int nsh = 0;
    bit ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge prog_clk);
      if (shift_en) nsh++;
      if (word_valid && word_ready) idx++;
      if (nsh >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge prog_clk); #1;
      start = 1'b0;
      word_valid = 1'b1;
      word_in = tb_words[idx % nwords];
    end
    check_eq("feed reached shift target", ok, 1);
  endtask

  task automatic begin_load(input int len, input bit ver, input int fault);
    tb_len = len;
    tb_fault = fault;
    @(posedge prog_clk); #1;
    start = 1'b1; chain_len = LW'(len); verify_en = ver;
    word_valid = 1'b1; word_in = tb_words[0];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rdy, shf, dn, dcyc;
    #3;
    check_eq("reset busy", busy, 0);
    check_eq("reset shift_en", shift_en, 0);
    check_eq("reset head", ccff_head, 0);
    check_eq("reset ready", word_ready, 0);
    check_eq("reset done", done, 0);
    check_eq("reset count", mismatch_count, 0);
    #20 prog_reset_n = 1'b1;

    tb_words[0] = 8'hA5; tb_words[1] = 8'h3C;
    run_load("basic", 12, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) tb_words[i] = 8'($urandom);
    run_load("starve", 16, 1'b0, 0, 5, 5, 1'b1);

    run_load("verify_good", 20, 1'b1, 0, 0, 0, 1'b0);

    tb_words[0] = 8'h07; tb_words[1] = 8'h0F; tb_words[2] = 8'hF0;
    run_load("verify_stuck", 20, 1'b1, 1, 0, 0, 1'b0);

    tb_words[0] = 8'h1F; tb_words[1] = 8'h00; tb_words[2] = 8'hF0;
    run_load("saturate", 20, 1'b1, 1, 0, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) tb_words[i] = 8'($urandom);
      run_load($sformatf("rand%0d", r), $urandom_range(64, 1), 1'($urandom),
               $urandom_range(2, 0), 0, $urandom_range(3, 0), 1'b0);
    end

    // Zero-length chain: done two cycles after start, no traffic.
    rdy = 0; shf = 0; dn = 0; dcyc = -1;
    @(posedge prog_clk); #1;
    start = 1'b1; chain_len = '0; verify_en = 1'b0; word_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge prog_clk);
      rdy += int'(word_ready);
      shf += int'(shift_en);
      if (done) begin
        dn++;
        dcyc = c;
      end
      @(posedge prog_clk); #1;
      start = 1'b0;
    end
    word_valid = 1'b0;
    check_eq("zero_len ready", rdy, 0);
    check_eq("zero_len shifts", shf, 0);
    check_eq("zero_len done pulses", dn, 1);
    check_eq("zero_len done cycle", dcyc, 2);

    // Abort after three pass-2 bits have been compared against a stuck-0 tail.
    tb_words[0] = 8'hFF;
    begin_load(8, 1'b1, 1);
    feed_until(1, 11);
    @(posedge prog_clk); #1;
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0; word_valid = 1'b0;
    @(negedge prog_clk);
    check_eq("abort busy", busy, 0);
    check_eq("abort shift_en", shift_en, 0);
    check_eq("abort ready", word_ready, 0);
    check_eq("abort mismatch kept", mismatch, 1);
    check_eq("abort count kept", mismatch_count, 3);
    check_eq("abort sat count kept", d2_cnt, 3);
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge prog_clk);
      dn += int'(done);
    end
    check_eq("abort no done", dn, 0);
    check_eq("abort count stable", mismatch_count, 3);

    // Async reset in the middle of a failing verify pass.
    tb_words[0] = 8'hFF; tb_words[1] = 8'hFF; tb_words[2] = 8'hFF;
    begin_load(24, 1'b1, 1);
    feed_until(3, 30);
    check_eq("pre-reset mismatch", mismatch, 1);
    check_eq("pre-reset count", mismatch_count, 5);
    @(posedge prog_clk); #2;
    prog_reset_n = 1'b0;
    #1;
    check_eq("async reset busy", busy, 0);
    check_eq("async reset shift_en", shift_en, 0);
    check_eq("async reset head", ccff_head, 0);
    check_eq("async reset ready", word_ready, 0);
    check_eq("async reset mismatch", mismatch, 0);
    check_eq("async reset count", mismatch_count, 0);
    word_valid = 1'b0; start = 1'b0;
    #20 prog_reset_n = 1'b1;

    for (int i = 0; i < 8; i++) tb_words[i] = 8'($urandom);
    run_load("post_reset", 33, 1'b1, 0, 0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Master end of the configuration chain (ccff_head → … → ccff_tail) that runs through every cby/cbx/sb/grid_io tile.
- Accepts bitstream words from the SoC/programming host over a valid/ready interface and serializes them LSB-first onto ccff_head.
- Drives a shift-enable for the fabric's prog_clk gate.
- Optionally runs a second identical pass and checks the looped-back ccff_tail bit-for-bit to verify the chain.

Parameters:
- WORD_W, 8: bitstream word width.
- LEN_W, 16: width of chain-length field; max chain length is 2^LEN_W-1 bits.
- ERR_W, 16: width of saturating mismatch counter.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  forces return to IDLE from any state.
- verify_en  input  1  latched at start; 1 = run verify pass after load.
- chain_len  input  LEN_W  number of chain flops; latched at start.
- word_in  input  WORD_W  bitstream word, bit 0 shifted first.
- word_valid  input  1  word_in valid.
- word_ready  output  1  loader accepts word_in this cycle.
- ccff_head  output  1  serial config bit to the first tile; registered.
- shift_en  output  1  registered; fabric chain captures ccff_head on the prog_clk edge where shift_en=1.
- ccff_tail  input  1  looped-back tail of the last tile.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  one-cycle pulse on normal completion.
- mismatch  output  1  sticky; set on any verify mismatch, cleared at start.
- mismatch_count  output  ERR_W  saturating count of verify mismatches, cleared at start.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, counters 0.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - start=1 latches chain_len and verify_en, and clears mismatch/mismatch_count.
  - chain_len=0 goes to DONE; otherwise goes to LOAD.
  - start is ignored outside IDLE.
- LOAD and VERIFY:
  - Internal WORD_W shift buffer with bit index; bits_left counter loaded with chain_len on entry.
  - Each cycle the buffer holds a bit: register ccff_head=buffer bit, shift_en=1, then decrement bits_left.
  - With no buffered bit: shift_en=0 and ccff_head holds its last value (starvation stall, chain does not shift).
- word_ready:
  - word_ready=1 iff state is LOAD/VERIFY, bits_left exceeds the bits remaining in the buffer, and the buffer is empty or its last bit is being consumed this cycle.
  - This gives gapless shifting with back-to-back words.
  - Once the final needed word has been accepted, word_ready stays 0.
  - Unused upper bits of the final word are discarded.
- Latency: first shift_en=1 occurs the cycle after the first word handshake.
- Pass ends when bits_left reaches 0.
  - LOAD → VERIFY if verify_en=1, otherwise → DONE.
  - VERIFY → DONE.
  - The buffer is empty on each transition.
  - On entering VERIFY, bits_left=chain_len again; the host must resend the identical bitstream.
- Verify compare:
  - On every prog_clk edge where shift_en=1 in VERIFY, sample ccff_tail and compare it with the ccff_head value being captured.
  - After a full chain_len-bit pass, the tail bit presents pass-1 bit i exactly when pass-2 bit i is at the head.
  - On inequality: mismatch←1 and mismatch_count increments, saturating at all-ones.
  - ccff_tail is ignored during LOAD.
- DONE: done=1 for one cycle, shift_en=0, then return to IDLE.
- abort, any state:
  - Next cycle: IDLE, shift_en=0, word_ready=0, buffer flushed, done not pulsed.
  - mismatch and mismatch_count keep their values.
  - abort has priority over start in the same cycle.
- Async reset mid-operation returns to the reset state immediately; no partial-word state survives.
- busy = state in {LOAD, VERIFY}.

Test Plan:
- Basic load, no verify:
  - Stimulus: chain_len=12, verify_en=0, words 0xA5 then 0x3C back-to-back.
  - Required: ccff_head sequence with shift_en=1 is 1,0,1,0,0,1,0,1,0,0,1,1, 12 consecutive cycles with no gap.
  - Required: word_ready=0 after the 2nd handshake; done pulses once; exactly 2 words accepted.
- Starvation:
  - Stimulus: chain_len=16, word_valid dropped for 5 cycles between words.
  - Required: shift_en=0 for those cycles, ccff_head stable, total shift_en count=16.
- Verify pass, good chain:
  - Stimulus: behavioural 20-flop shift-register model between ccff_head and ccff_tail; chain_len=20; verify_en=1; 3 words sent twice.
  - Required: mismatch=0, mismatch_count=0, done after 40 shifts.
- Verify pass, broken chain:
  - Stimulus: model with tail stuck at 0, bitstream containing seven 1s in 20 bits.
  - Required: mismatch=1, mismatch_count=7.
- Saturation:
  - Stimulus: ERR_W=2, stuck-at fault producing 5 mismatches.
  - Required: mismatch_count=3.
- Edge and control cases:
  - chain_len=0 start → done pulse 2 cycles later, no word_ready, no shift_en.
  - abort mid-LOAD → IDLE next cycle, no done.
  - start during busy → ignored.
  - prog_reset_n asserted mid-VERIFY → all outputs 0 asynchronously.
